// File: rtl/uart_tx.sv
// 8N1 UART transmitter, LSB first, idles high; CLKS_PER_BIT clocks per bit.
// Define UART_TX_PARITY_EN to insert an even-parity bit between DATA and STOP.
module uart_tx #(
    parameter int CLKS_PER_BIT = 29
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tx_start,
    input  logic [7:0] tx_data,
    output logic       rs232,
    output logic       busy,
    output logic       done
);

    localparam int BAUD_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

    // state | meaning: IDLE line high | START low bit | DATA lsb first | PARITY even | STOP high bit
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
`ifdef UART_TX_PARITY_EN
    localparam logic [2:0] S_PARITY = 3'd3;
`endif
    localparam logic [2:0] S_STOP   = 3'd4;

    logic [2:0]        state_q, state_d;
    logic [BAUD_W-1:0] baud_q, baud_d;
    logic [2:0]        bit_q, bit_d;
    logic [7:0]        shift_q, shift_d;
    logic              rs232_q, rs232_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              armed_q;
    logic              baud_wrap;
`ifdef UART_TX_PARITY_EN
    logic              parity_q, parity_d;
`endif

    assign baud_wrap = (baud_q == BAUD_LAST);

    always_comb begin
        state_d = state_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        rs232_d = rs232_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_d = parity_q;
`endif
        if (state_q == S_IDLE || baud_wrap) begin
            baud_d = '0;
        end else begin
            baud_d = baud_q + BAUD_W'(1);
        end

        case (state_q)
            S_IDLE: begin
                rs232_d = 1'b1;
                busy_d  = 1'b0;
                // armed_q keeps a request on the reset-release edge from being taken
                if (tx_start && armed_q) begin
                    shift_d = tx_data;
                    bit_d   = 3'd0;
                    state_d = S_START;
                    rs232_d = 1'b0;
                    busy_d  = 1'b1;
`ifdef UART_TX_PARITY_EN
                    parity_d = ^tx_data;
`endif
                end
            end
            S_START: begin
                if (baud_wrap) begin
                    state_d = S_DATA;
                    rs232_d = shift_q[0];
                end
            end
            S_DATA: begin
                if (baud_wrap) begin
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d = S_PARITY;
                        rs232_d = parity_q;
`else
                        state_d = S_STOP;
                        rs232_d = 1'b1;
`endif
                    end else begin
                        bit_d   = bit_q + 3'd1;
                        rs232_d = shift_q[1];
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (baud_wrap) begin
                    state_d = S_STOP;
                    rs232_d = 1'b1;
                end
            end
`endif
            S_STOP: begin
                if (baud_wrap) begin
                    state_d = S_IDLE;
                    rs232_d = 1'b1;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                rs232_d = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            baud_q  <= '0;
            bit_q   <= 3'd0;
            shift_q <= 8'd0;
            rs232_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            armed_q <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            rs232_q <= rs232_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            armed_q <= 1'b1;
        end
    end

`ifdef UART_TX_PARITY_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            parity_q <= 1'b0;
        end else begin
            parity_q <= parity_d;
        end
    end
`endif

    assign rs232 = rs232_q;
    assign busy  = busy_q;
    assign done  = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: a scoreboard of sent bytes is checked against a
// mid-bit sampling receiver model, along with busy/done frame timing.
module tb_uart_tx;

    localparam int N = 29;
`ifdef UART_TX_PARITY_EN
    localparam int FB = 11;
`else
    localparam int FB = 10;
`endif
    localparam int FRAME = FB * N;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tx_start = 1'b0;
    logic [7:0] tx_data = 8'd0;
    logic       rs232;
    logic       busy;
    logic       done;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] sb_q[$];

    always #5 clk = ~clk;

    uart_tx #(.CLKS_PER_BIT(N)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .tx_start (tx_start),
        .tx_data  (tx_data),
        .rs232    (rs232),
        .busy     (busy),
        .done     (done)
    );

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // called on a falling edge; returns right after the accepting edge E0
    task automatic launch(input logic [7:0] d);
        tx_start = 1'b1;
        tx_data  = d;
        sb_q.push_back(d);
        @(posedge clk);
    endtask

    // cycle t is observed on the falling edge following edge E0+t
    task automatic run_frame(input string tag, input bit keep, input int inj_at,
                             input logic [7:0] inj_dat, input int rst_at);
        logic [FB-1:0] samp;
        logic [7:0]    expd;
        int            done_cnt;
        int            done_at;
        int            busy_fall;
        logic          end_line;
        samp      = '0;
        done_cnt  = 0;
        done_at   = -1;
        busy_fall = -1;
        end_line  = 1'b0;
        expd      = sb_q.pop_front();
        for (int t = 0; t <= FRAME; t++) begin
            @(negedge clk);
            if (t == 0) begin
                chk({tag, " start edge rs232"}, 32'(rs232), 32'd0);
                chk({tag, " start edge busy"}, 32'(busy), 32'd1);
                if (!keep) tx_start = 1'b0;
            end
            if (t == 5) tx_data = 8'($urandom);
            if (inj_at >= 0 && t == inj_at) begin
                tx_start = 1'b1;
                tx_data  = inj_dat;
            end
            if (inj_at >= 0 && t == inj_at + 1) tx_start = 1'b0;
            if (done) begin
                done_cnt++;
                done_at = t;
            end
            if (!busy && busy_fall < 0) busy_fall = t;
            for (int k = 0; k < FB; k++) begin
                if (t == k * N + N / 2) samp[k] = rs232;
            end
            if (t == FRAME) end_line = rs232;
            if (rst_at >= 0 && t == rst_at) begin
                rst_n = 1'b0;
                #1;
                chk({tag, " async reset rs232"}, 32'(rs232), 32'd1);
                chk({tag, " async reset busy"}, 32'(busy), 32'd0);
                chk({tag, " async reset done"}, 32'(done), 32'd0);
                repeat (5) begin
                    @(negedge clk);
                    if (done) done_cnt++;
                end
                chk({tag, " no done after abort"}, 32'(done_cnt), 32'd0);
                rst_n = 1'b1;
                return;
            end
        end
        chk({tag, " start bit"}, 32'(samp[0]), 32'd0);
        chk({tag, " data byte"}, 32'(samp[8:1]), 32'(expd));
`ifdef UART_TX_PARITY_EN
        chk({tag, " parity bit"}, 32'(samp[9]), 32'(^expd));
`endif
        chk({tag, " stop bit"}, 32'(samp[FB-1]), 32'd1);
        chk({tag, " busy fall cycle"}, 32'(busy_fall), 32'(FRAME));
        chk({tag, " done count"}, 32'(done_cnt), 32'd1);
        chk({tag, " done cycle"}, 32'(done_at), 32'(FRAME));
        chk({tag, " line high at done"}, 32'(end_line), 32'd1);
    endtask

    initial begin
        int           bad;
        logic [7:0]   lb[3];
        lb[0] = 8'h55;
        lb[1] = 8'h81;
        lb[2] = 8'h07;

        rst_n    = 1'b0;
        tx_start = 1'b0;
        repeat (5) begin
            @(negedge clk);
            chk("reset rs232", 32'(rs232), 32'd1);
            chk("reset busy", 32'(busy), 32'd0);
            chk("reset done", 32'(done), 32'd0);
        end
        rst_n = 1'b1;
        bad = 0;
        repeat (100) begin
            @(negedge clk);
            if (rs232 !== 1'b1 || busy !== 1'b0 || done !== 1'b0) bad++;
        end
        chk("idle after reset", 32'(bad), 32'd0);

        launch(8'hA5);
        run_frame("a5", 1'b0, 100, 8'hFF, -1);
        bad = 0;
        repeat (12 * N) begin
            @(negedge clk);
            if (done !== 1'b0 || busy !== 1'b0 || rs232 !== 1'b1) bad++;
        end
        chk("ignored request not queued", 32'(bad), 32'd0);

        launch(8'h00);
        run_frame("b2b 00", 1'b1, -1, 8'h00, -1);
        launch(8'hFF);
        run_frame("b2b ff", 1'b0, -1, 8'h00, -1);
        repeat (3) @(negedge clk);

        for (int i = 0; i < 3; i++) begin
            launch(lb[i]);
            run_frame($sformatf("loop %02h", lb[i]), 1'b0, -1, 8'h00, -1);
            repeat (3) @(negedge clk);
        end

        launch(8'h3C);
        run_frame("rst 3c", 1'b0, -1, 8'h00, 150);
        repeat (2) @(negedge clk);
        chk("idle after abort rs232", 32'(rs232), 32'd1);
        chk("idle after abort busy", 32'(busy), 32'd0);
        launch(8'h3C);
        run_frame("3c after reset", 1'b0, -1, 8'h00, -1);
        repeat (3) @(negedge clk);

        rst_n = 1'b0;
        @(negedge clk);
        tx_start = 1'b1;
        tx_data  = 8'h5A;
        @(posedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("start on release edge ignored", 32'(busy), 32'd0);
        tx_start = 1'b0;
        repeat (3) @(negedge clk);
        chk("idle after release", 32'(busy), 32'd0);

        chk("scoreboard drained", 32'(sb_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
# uart_tx

UART transmitter for the UART subsystem. It serialises one byte per request into an 8N1 frame on `rs232`: one start bit, eight data bits LSB first, and one stop bit, with no parity by default. Its bit period matches the team's UART receiver (29 clocks per bit by default), so the two can be looped back directly. It sits between a byte-producing host (FSM or FIFO) and the TX pin.

## Interface
- `CLKS_PER_BIT`, default 29. Clock cycles per serial bit; must be ≥ 2.
- `clk`  input  1  system clock; all logic on the rising edge.
- `rst_n`  input  1  reset, asynchronous, active-low.
- `tx_start`  input  1  request; sampled only in IDLE.
- `tx_data`  input  8  byte to send; captured on the edge that accepts `tx_start`.
- `rs232`  output  1  serial line, registered, idles high.
- `busy`  output  1  high from acceptance until the end of the stop bit.
- `done`  output  1  one-cycle pulse at frame completion.

## Operation
- States:
  - IDLE → START → DATA → STOP → IDLE.
  - With `UART_TX_PARITY_EN` defined: DATA → PARITY → STOP.
- IDLE:
  - `rs232`=1, `busy`=0.
  - `tx_start`=1 latches `tx_data` into a shift register, clears the counters, and moves to START.
- START: `rs232`=0 for `CLKS_PER_BIT` cycles.
- DATA:
  - `rs232` = shift register bit 0.
  - A bit counter (0..7) advances each time the baud counter wraps.
  - The shift register shifts right on each bit boundary.
  - Leaves DATA after bit 7's period.
- STOP:
  - `rs232`=1 for `CLKS_PER_BIT` cycles.
  - At the end of the stop bit: state → IDLE, `busy`=0, and `done`=1 for one cycle.
- Baud counter:
  - Width `$clog2(CLKS_PER_BIT)`; counts 0..`CLKS_PER_BIT`-1 and wraps.
  - Runs only outside IDLE; held at 0 in IDLE.
- `tx_start` while `busy`=1 is ignored; it is not queued.
- Changes to `tx_data` after acceptance have no effect on the frame in flight.
- Reset asserted mid-frame:
  - All state is cleared immediately: `rs232`=1, `busy`=0, `done`=0, IDLE.
  - The partial frame is abandoned; no `done` pulse.

## Timing
- Reset values: `rs232`=1, `busy`=0, `done`=0, internal registers 0.
- Acceptance at edge E0:
  - `busy` and the falling start edge of `rs232` both appear after E0, with no extra latency.
- Bit k (k=0 start, 1..8 data, 9 stop) occupies cycles E0+k·N … E0+(k+1)·N−1, where N=`CLKS_PER_BIT`.
- Frame end at edge E0+10·N (E0+11·N with parity): `busy` falls and `done` rises in the same cycle.
- Back-to-back frames:
  - `tx_start` held high through the `done` cycle is accepted on the next edge, E0+10·N+1.
  - The stop bit is therefore N+1 cycles long. This gap is the required minimum.
- `tx_start` coincident with the reset release edge is not accepted.

## Configuration
- `UART_TX_PARITY_EN`
  - **Defined:** a PARITY state is inserted after DATA. `rs232` = XOR of the 8 data bits (even parity) for N cycles. The frame is 11·N cycles; `done` and `busy` timing shift by N accordingly.
  - **Undefined:** 8N1 only; no parity logic synthesised.

## Test plan
- **Reset:** hold `rst_n`=0 for 5 cycles, `tx_start`=0 → `rs232`=1, `busy`=0, `done`=0 throughout; stays idle-high 100 cycles after release.
- **Single frame:** `tx_data`=8'hA5, one-cycle `tx_start` at E0, N=29.
  - Sample `rs232` mid-bit → 0,1,0,1,0,0,1,0,1,1.
  - `done` pulses exactly once at E0+290.
  - `busy` high for cycles E0..E0+289.
- **Ignored request:** second `tx_start` with 8'hFF at E0+100 → frame still carries 8'hA5; only one `done`.
- **Back-to-back:** `tx_start` held high with 8'h00 then 8'hFF.
  - Second start bit begins at E0+291.
  - Two `done` pulses, 291 cycles apart.
- **Mid-frame reset:** assert `rst_n`=0 at E0+150 of a 8'h3C frame → `rs232`=1 and `busy`=0 asynchronously; no `done`; a new 8'h3C frame after release completes normally.
- **Loopback/parity:**
  - Drive the UART receiver from `rs232` with 8'h00, 8'h55, 8'hFF, 8'h81 → each received byte equals the sent byte.
  - With `UART_TX_PARITY_EN`: 8'h07 gives parity bit 1; `done` at E0+319.
